// File: rtl/intrpt_ctrl_if.sv
// Interrupt controller bus: request/mask/boundary inputs from the core and
// peripherals, trap/resume redirects and register-bank controls back out.
`timescale 1ns/1ps

interface intrpt_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SRC    = 4
);
    logic [NUM_SRC-1:0]    irq_req;
    logic [NUM_SRC-1:0]    irq_mask;
    logic                  instr_boundary;
    logic [DATA_WIDTH-1:0] cur_pc;
    logic                  iret;

    logic                  trap;
    logic [DATA_WIDTH-1:0] trap_vector;
    logic                  resume;
    logic [DATA_WIDTH-1:0] resume_pc;
    logic                  intrpt;
    logic [DATA_WIDTH-1:0] intrpt_val;
    logic                  save_proc_pc;
    logic [DATA_WIDTH-1:0] proc_pc;
    logic                  rd_shft_enabler;
    logic                  wrt_shft_enabler;
    logic                  busy;

    // Core / peripheral side
    modport master (
        output irq_req, irq_mask, instr_boundary, cur_pc, iret,
        input  trap, trap_vector, resume, resume_pc, intrpt, intrpt_val,
               save_proc_pc, proc_pc, rd_shft_enabler, wrt_shft_enabler, busy
    );

    // Controller side
    modport slave (
        input  irq_req, irq_mask, instr_boundary, cur_pc, iret,
        output trap, trap_vector, resume, resume_pc, intrpt, intrpt_val,
               save_proc_pc, proc_pc, rd_shft_enabler, wrt_shft_enabler, busy
    );
endinterface

// File: rtl/intrpt_ctrl.sv
// Single-level interrupt entry/exit controller. Latches request edges, takes
// the highest-priority unmasked source at an instruction boundary, redirects
// the PC to its vector and switches the register bank to the shadow copy
// while the handler runs.
`timescale 1ns/1ps

module intrpt_ctrl #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_SRC    = 4,
    parameter logic [DATA_WIDTH-1:0] VEC_BASE   = 32'h0000_0040
) (
    input  logic          clk,
    input  logic          rst_n,
    intrpt_ctrl_if.slave  bus
);

    localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ENTER,
        IN_ISR,
        EXIT
    } stateT;

    stateT                 state;
    stateT                 stateNext;

    logic [NUM_SRC-1:0]    prevReq;
    logic [NUM_SRC-1:0]    pending;
    logic [NUM_SRC-1:0]    readyMask;
    logic [NUM_SRC-1:0]    captureClr;
    logic                  capture;
    logic [ID_W-1:0]       srcSel;
    logic [ID_W-1:0]       srcId;
    logic [DATA_WIDTH-1:0] idExt;
    logic [DATA_WIDTH-1:0] epc;

    logic                  trapNext;
    logic [DATA_WIDTH-1:0] trapVecNext;
    logic                  resumeNext;
    logic [DATA_WIDTH-1:0] resumePcNext;
    logic                  intrptNext;
    logic                  savePcNext;
    logic                  shadowSel;

    assign idExt = {{(DATA_WIDTH-ID_W){1'b0}}, srcId};

    // Pick the lowest-index pending, unmasked source and decide whether to take it now
    always_comb begin
        readyMask  = pending & bus.irq_mask;
        srcSel     = '0;
        captureClr = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (readyMask[i]) begin
                srcSel = ID_W'(i);
            end
        end
        capture = (state == IDLE) && (|readyMask) && bus.instr_boundary;
        if (capture) begin
            captureClr[srcSel] = 1'b1;
        end
    end

    // Next-state and per-state output decode
    always_comb begin
        stateNext    = state;
        trapNext     = 1'b0;
        trapVecNext  = '0;
        resumeNext   = 1'b0;
        resumePcNext = '0;
        intrptNext   = 1'b0;
        savePcNext   = 1'b0;
        shadowSel    = 1'b0;
        case (state)
            IDLE: begin
                if (capture) begin
                    stateNext = ENTER;
                end
            end
            ENTER: begin
                trapNext    = 1'b1;
                trapVecNext = VEC_BASE + (idExt << 2);
                intrptNext  = 1'b1;
                stateNext   = IN_ISR;
            end
            IN_ISR: begin
                shadowSel = 1'b1;
                if (bus.iret) begin
                    stateNext = EXIT;
                end
            end
            EXIT: begin
                resumeNext   = 1'b1;
                resumePcNext = epc;
                savePcNext   = 1'b1;
                stateNext    = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State register; reset drops straight back to IDLE so the bank select clears at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Rising-edge detect into sticky pending bits; a new edge beats a same-cycle capture clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prevReq <= '0;
            pending <= '0;
        end else begin
            prevReq <= bus.irq_req;
            pending <= (pending & ~captureClr) | (bus.irq_req & ~prevReq);
        end
    end

    // Remember which source was taken and where to resume
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            srcId <= '0;
            epc   <= '0;
        end else if (capture) begin
            srcId <= srcSel;
            epc   <= bus.cur_pc;
        end
    end

    assign bus.trap             = trapNext;
    assign bus.trap_vector      = trapVecNext;
    assign bus.resume           = resumeNext;
    assign bus.resume_pc        = resumePcNext;
    assign bus.intrpt           = intrptNext;
    assign bus.intrpt_val       = idExt;
    assign bus.save_proc_pc     = savePcNext;
    assign bus.proc_pc          = epc;
    assign bus.rd_shft_enabler  = shadowSel;
    assign bus.wrt_shft_enabler = shadowSel;
    assign bus.busy             = (state != IDLE);

endmodule

// File: doc/intrpt_ctrl.md
# intrpt_ctrl

Interrupt entry/exit controller sitting directly upstream of the register bank. It latches peripheral interrupt requests, picks the highest-priority unmasked source at an instruction boundary, and redirects the PC to a vector. It drives the bank's interrupt-write (`intrpt`/`intrpt_val`), return-PC write (`save_proc_pc`/`proc_pc`) and bank-select (`rd_shft_enabler`/`wrt_shft_enabler`) inputs, so handlers run in the shadow bank. Single-level: no nesting.

## Interface
- `DATA_WIDTH`, 32, data/PC width
- `NUM_SRC`, 4, number of interrupt sources (index 0 = highest priority)
- `VEC_BASE`, 32'h0000_0040, word address of vector 0; vector stride 4 words

- `clk` in 1 — single clock, all state on posedge
- `rst_n` in 1 — asynchronous, active-low reset
- `irq_req` in NUM_SRC — synchronous request lines, rising-edge triggered
- `irq_mask` in NUM_SRC — 1 = source enabled
- `instr_boundary` in 1 — core is between instructions, trap allowed this cycle
- `cur_pc` in DATA_WIDTH — PC of next instruction to execute (resume address)
- `iret` in 1 — return-from-interrupt decoded this cycle
- `trap` out 1 — one-cycle PC redirect pulse
- `trap_vector` out DATA_WIDTH — redirect target, valid with `trap`
- `resume` out 1 — one-cycle PC restore pulse
- `resume_pc` out DATA_WIDTH — restore target, valid with `resume`
- `intrpt` out 1 — bank writes `intrpt_val` into register 2 (bank 0)
- `intrpt_val` out DATA_WIDTH — cause word: source id zero-extended
- `save_proc_pc` out 1 — bank writes `proc_pc` into register 2 (bank 0)
- `proc_pc` out DATA_WIDTH — saved interrupted PC (epc)
- `rd_shft_enabler`, `wrt_shft_enabler` out 1 — 1 = shadow bank selected
- `busy` out 1 — high in every state except IDLE

## Operation
- Edge detect: `prev_req` register; `pending[i]` set when `irq_req[i] & ~prev_req[i]`. Pending bits survive masking and ISR execution.
- `pending[id]` cleared on capture. Set and clear on the same bit in the same cycle: set wins.
- FSM states: IDLE, ENTER, IN_ISR, EXIT.
- IDLE: if `(pending & irq_mask) != 0` and `instr_boundary`, then capture `id` = lowest set index, `epc <= cur_pc`, clear `pending[id]`, go to ENTER. Otherwise stay.
- ENTER (1 cycle): `trap=1`, `trap_vector = VEC_BASE + (id<<2)`, `intrpt=1`, `intrpt_val = id`. Go to IN_ISR.
- IN_ISR: both shift enablers = 1. `iret` goes to EXIT. New requests only latch into pending.
- EXIT (1 cycle): `resume=1`, `resume_pc = epc`, `save_proc_pc=1`, `proc_pc = epc`, shift enablers = 0. Go to IDLE.
- `iret` outside IN_ISR is ignored.
- `intrpt` and `save_proc_pc` are never high in the same cycle; they target the same register.
- `intrpt_val` and `proc_pc` hold their last captured values between pulses.

## Timing
- Reset (async, immediate): state IDLE; `pending`, `prev_req`, `epc`, `id` = 0; every output 0.
- A request held high across reset release is seen as a rising edge on the first clock after release.
- Latency: request edge sampled at edge N sets pending. With boundary high in the following cycle, capture happens at edge N+1 and `trap`/`intrpt` are high in the cycle after edge N+1.
- Shift enablers rise the cycle after `trap` and fall in the EXIT cycle.
- The earliest re-entry is the cycle after EXIT, when IDLE re-evaluates pending.
- Reset mid-ISR: banks return to 0 immediately; epc and pending are lost.
- Vector arithmetic is modulo 2^DATA_WIDTH.

## Test plan
- Reset with `irq_req=4'b1111`: all outputs 0 while `rst_n=0`. Release with `irq_req` held, `irq_mask=4'b0001`, boundary=1: `trap` in the 2nd cycle after release, `trap_vector=0x40`, `intrpt_val=0`.
- Edges on sources 2 and 3 in the same cycle, mask `4'b1111`: first `trap_vector=0x48`, `intrpt_val=2`. After `iret`/EXIT: `trap_vector=0x4C`, `intrpt_val=3`.
- Source 1 edge with mask 0 for 10 cycles: no `trap`, `busy=0`. Set mask bit 1: `trap`, `trap_vector=0x44`.
- Pending with `instr_boundary=0` for 5 cycles: no `trap`. Boundary=1 with `cur_pc=0x123`: `trap`, then after `iret`: `resume_pc=0x123`, `proc_pc=0x123`.
- In IN_ISR: `rd_shft_enabler=wrt_shft_enabler=1`, `busy=1`. `iret` gives an EXIT cycle with `resume=save_proc_pc=1` and enablers 0. `iret` pulsed in IDLE: no output change.
- Reset asserted mid-ISR: enablers, `busy`, `proc_pc` drop to 0 asynchronously. No `resume` is issued after release.
